// File: rtl/frame_buffer_pkg.sv
// Shared sizing, write payload type and colour palette for the double-buffered frame store.
// Render geometry is taken from `DISPLAY_WIDTH/`DISPLAY_HEIGHT/`H_BITS/`V_BITS/`COLOR_BITS when predefined.
`ifndef DISPLAY_WIDTH
`define DISPLAY_WIDTH 16
`endif
`ifndef DISPLAY_HEIGHT
`define DISPLAY_HEIGHT 16
`endif
`ifndef H_BITS
`define H_BITS 5
`endif
`ifndef V_BITS
`define V_BITS 5
`endif
`ifndef COLOR_BITS
`define COLOR_BITS 4
`endif

package frame_buffer_pkg;
  localparam int unsigned DISPLAY_WIDTH  = `DISPLAY_WIDTH;
  localparam int unsigned DISPLAY_HEIGHT = `DISPLAY_HEIGHT;
  localparam int unsigned H_BITS         = `H_BITS;
  localparam int unsigned V_BITS         = `V_BITS;
  localparam int unsigned COLOR_BITS     = `COLOR_BITS;
  localparam int unsigned VGA_H_BITS     = 11;
  localparam int unsigned VGA_V_BITS     = 10;
  localparam int unsigned SCALE_SHIFT    = 2;
  localparam int unsigned PIX_COUNT      = DISPLAY_WIDTH * DISPLAY_HEIGHT;
  localparam int unsigned FB_DEPTH       = 2 * PIX_COUNT;
  localparam int unsigned FB_ADDR_BITS   = $clog2(FB_DEPTH);

  typedef logic [11:0] rgb444_t;

  typedef struct packed {
    logic                  sel;
    logic [V_BITS-1:0]     v;
    logic [H_BITS-1:0]     h;
    logic [COLOR_BITS-1:0] color;
  } wr_pix_t;

  // Escape-time style ramp: dark blue through green and orange to white.
  localparam rgb444_t FRACTAL_PALETTE [16] = '{
    12'h000, 12'h00F, 12'h01E, 12'h03D, 12'h05C, 12'h08A, 12'h0A8, 12'h2C6,
    12'h4D4, 12'h7E2, 12'hAE0, 12'hDD0, 12'hFB0, 12'hF80, 12'hF40, 12'hFFF
  };

  function automatic rgb444_t grey_map(input logic [COLOR_BITS-1:0] c);
    return rgb444_t'({c, c, c});
  endfunction
endpackage

// File: rtl/frame_buffer_bram.sv
// Simple dual-port frame memory: port A writes, port B reads with a 2-cycle registered output.
module frame_buffer_bram
  import frame_buffer_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_wr_en,
  input  logic [FB_ADDR_BITS-1:0] i_wr_addr,
  input  logic [COLOR_BITS-1:0]   i_wr_data,
  input  logic [FB_ADDR_BITS-1:0] i_rd_addr,
  output logic [COLOR_BITS-1:0]   o_rd_data
);
  logic [COLOR_BITS-1:0] r_mem [FB_DEPTH];
  logic [COLOR_BITS-1:0] r_rd_q1;
  logic [COLOR_BITS-1:0] r_rd_q2;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    r_rd_q1 <= r_mem[i_rd_addr];
    r_rd_q2 <= r_rd_q1;
  end

  assign o_rd_data = r_rd_q2;
endmodule

// File: rtl/frame_buffer.sv
// Double-buffered frame store: render pixels go to the back buffer, VGA scan-out reads the front one.
// FRAME_BUFFER_PALETTE_EN selects the palette colour map (4-cycle read latency) instead of greyscale (3).
module frame_buffer
  import frame_buffer_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [H_BITS-1:0]     hcount_in,
  input  logic [V_BITS-1:0]     vcount_in,
  input  logic [COLOR_BITS-1:0] color_in,
  input  logic                  valid_in,
  input  logic                  new_frame_in,
  input  logic [VGA_H_BITS-1:0] vga_hcount_in,
  input  logic [VGA_V_BITS-1:0] vga_vcount_in,
  output logic [11:0]           pixel_out,
  output logic                  front_sel_out,
  output logic [15:0]           frame_count_out
);
  logic                    r_front_sel;
  logic [15:0]             r_frame_count;
  logic                    r_w0_vld;
  wr_pix_t                 r_w0_pix;
  logic                    r_w1_vld;
  logic [FB_ADDR_BITS-1:0] r_w1_addr;
  logic [COLOR_BITS-1:0]   r_w1_data;
  logic                    r_r1_show;
  logic                    r_r2_show;
  rgb444_t                 r_pixel;
  logic                    w_in_range;
  logic [FB_ADDR_BITS-1:0] w_w0_addr;
  logic                    w_wr_en;
  logic [VGA_H_BITS-1:0]   w_rx;
  logic [VGA_V_BITS-1:0]   w_ry;
  logic                    w_blank;
  logic [FB_ADDR_BITS-1:0] w_rd_addr;
  logic [COLOR_BITS-1:0]   w_rd_data;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_front_sel   <= 1'b0;
      r_frame_count <= '0;
    end else if (new_frame_in) begin
      r_front_sel   <= ~r_front_sel;
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  // Write path: out-of-range pixels never become valid; the tag is the pre-swap back buffer.
  assign w_in_range = (32'(hcount_in) < DISPLAY_WIDTH) && (32'(vcount_in) < DISPLAY_HEIGHT);
  assign w_w0_addr  = FB_ADDR_BITS'(r_w0_pix.v) * FB_ADDR_BITS'(DISPLAY_WIDTH)
                    + FB_ADDR_BITS'(r_w0_pix.h)
                    + (r_w0_pix.sel ? FB_ADDR_BITS'(PIX_COUNT) : '0);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_w0_vld <= 1'b0;
      r_w1_vld <= 1'b0;
    end else begin
      r_w0_vld <= valid_in && w_in_range;
      r_w1_vld <= r_w0_vld;
    end
  end

  always_ff @(posedge clk_in) begin
    r_w0_pix.sel   <= ~r_front_sel;
    r_w0_pix.v     <= vcount_in;
    r_w0_pix.h     <= hcount_in;
    r_w0_pix.color <= color_in;
    r_w1_addr      <= w_w0_addr;
    r_w1_data      <= r_w0_pix.color;
  end

  // A reset landing on the commit cycle still drops the in-flight pixel.
  assign w_wr_en = r_w1_vld & ~rst_in;

  assign w_rx      = vga_hcount_in >> SCALE_SHIFT;
  assign w_ry      = vga_vcount_in >> SCALE_SHIFT;
  assign w_blank   = (32'(w_rx) >= DISPLAY_WIDTH) || (32'(w_ry) >= DISPLAY_HEIGHT);
  assign w_rd_addr = w_blank ? '0
                   : FB_ADDR_BITS'(w_ry) * FB_ADDR_BITS'(DISPLAY_WIDTH) + FB_ADDR_BITS'(w_rx)
                     + (r_front_sel ? FB_ADDR_BITS'(PIX_COUNT) : '0);

  frame_buffer_bram u_bram (
    .i_clk     (clk_in),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_w1_addr),
    .i_wr_data (r_w1_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // show = read slot valid and not blanked, tracked alongside the memory read latency.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_r1_show <= 1'b0;
      r_r2_show <= 1'b0;
    end else begin
      r_r1_show <= ~w_blank;
      r_r2_show <= r_r1_show;
    end
  end

`ifdef FRAME_BUFFER_PALETTE_EN
  logic                  r_r3_show;
  logic [COLOR_BITS-1:0] r_r3_color;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_r3_show <= 1'b0;
      r_pixel   <= '0;
    end else begin
      r_r3_show <= r_r2_show;
      r_pixel   <= r_r3_show ? FRACTAL_PALETTE[4'(r_r3_color)] : '0;
    end
  end

  always_ff @(posedge clk_in) begin
    r_r3_color <= w_rd_data;
  end
`else
  always_ff @(posedge clk_in) begin
    if (rst_in) r_pixel <= '0;
    else        r_pixel <= r_r2_show ? grey_map(w_rd_data) : '0;
  end
`endif

  assign pixel_out       = r_pixel;
  assign front_sel_out   = r_front_sel;
  assign frame_count_out = r_frame_count;
endmodule
